// File: rtl/pe_pkg.sv
// Shared types and width helpers for the systolic PE.
// Imported by pe_acc and pe_lane_mac.
package pe_pkg;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_st_t;

  function automatic int acc_w(int lw, int tw, int n);
    return lw + tw + ((n > 1) ? $clog2(n) : 1);
  endfunction

  function automatic int lane_lo(int lane, int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/pe_lane_mac.sv
// One lane: multiply shared left operand by lane top operand
// and accumulate; exposes the next sum for the output register.
module pe_lane_mac #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             en,
  input  logic             start,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_next
);

  localparam int P_W = A_W + B_W;
  localparam bit SGN = (SIGNED != 0);

  logic [P_W-1:0]   a_x;
  logic [P_W-1:0]   b_x;
  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc;

  // Full-width extend first so the low P_W bits are exact either way.
  assign a_x = {{B_W{SGN & a[A_W-1]}}, a};
  assign b_x = {{A_W{SGN & b[B_W-1]}}, b};
  assign prod = a_x * b_x;
  assign prod_ext = {{(ACC_W-P_W){SGN & prod[P_W-1]}}, prod};

  assign acc_next = (start ? '0 : acc) + prod_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pe_acc.sv
// Systolic PE: forwards operands, accumulates LANES dot products
// of NUM terms and hands results out through a valid/ready register.
module pe_acc
  import pe_pkg::*;
#(
  parameter int NUM      = 3,
  parameter int INLEFT_W = 8,
  parameter int INTOP_W  = 8,
  parameter int LANES    = 1,
  parameter int SIGNED   = 1,
  localparam int ACC_W   = acc_w(INLEFT_W, INTOP_W, NUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INLEFT_W-1:0]      in1,
  input  logic [LANES*INTOP_W-1:0] in2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [INLEFT_W-1:0]      o_r,
  output logic [LANES*INTOP_W-1:0] o_b,
  output logic                     o_fwd_valid,
  output logic [LANES*ACC_W-1:0]   o,
  output logic                     o_valid,
  input  logic                     o_ready
);

  localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM - 1);

  logic [CNT_W-1:0]       cnt;
  logic                   last;
  logic                   accept;
  logic                   done;
  logic                   drain;
  logic [LANES*ACC_W-1:0] sum_next;
  out_st_t                state;

  assign last     = (cnt == LAST);
  assign o_valid  = (state == OUT_FULL);
  assign in_ready = !(last && o_valid && !o_ready);
  assign accept   = in_valid && in_ready && !clear;
  assign done     = accept && last;
  assign drain    = o_valid && o_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_lane_mac #(
      .A_W   (INLEFT_W),
      .B_W   (INTOP_W),
      .ACC_W (ACC_W),
      .SIGNED(SIGNED)
    ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .a       (in1),
      .b       (in2[lane_lo(l, INTOP_W) +: INTOP_W]),
      .en      (accept),
      .start   (cnt == '0),
      .clr     (clear),
      .acc_next(sum_next[lane_lo(l, ACC_W) +: ACC_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_r         <= '0;
      o_b         <= '0;
      o_fwd_valid <= 1'b0;
    end else begin
      o_fwd_valid <= accept;
      if (accept) begin
        o_r <= in1;
        o_b <= in2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OUT_EMPTY;
      o     <= '0;
    end else begin
      if (done) begin
        o <= sum_next;
      end
      unique case (state)
        OUT_EMPTY: if (done) state <= OUT_FULL;
        OUT_FULL:  if (drain && !done) state <= OUT_EMPTY;
        default:   state <= OUT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_acc.sv
// Randomised and directed bench for pe_acc (signed and unsigned
// builds side by side) against a term-list reference model.
module tb_pe_acc;

  localparam int NUM = 3;
  localparam int AW  = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in1 = '0;
  logic [15:0] in2 = '0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        o_ready = 1'b0;

  logic        ir_s, ir_u, fv_s, fv_u, ov_s, ov_u;
  logic [7:0]  or_s, or_u;
  logic [15:0] ob_s, ob_u;
  logic [35:0] o_s, o_u;

  int n_chk = 0;
  int n_err = 0;

  int     m_n;
  longint m_ps[2], m_pu[2], m_os[2], m_ou[2];
  bit     m_ov, m_fv;
  logic [7:0]  m_r;
  logic [15:0] m_b;
  bit     last_ir;

  always #5 clk = ~clk;

  pe_acc #(.NUM(NUM), .INLEFT_W(8), .INTOP_W(8),
           .LANES(2), .SIGNED(1)) u_dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2),
    .in_valid(in_valid), .in_ready(ir_s), .clear(clear),
    .o_r(or_s), .o_b(ob_s), .o_fwd_valid(fv_s),
    .o(o_s), .o_valid(ov_s), .o_ready(o_ready));

  pe_acc #(.NUM(NUM), .INLEFT_W(8), .INTOP_W(8),
           .LANES(2), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2),
    .in_valid(in_valid), .in_ready(ir_u), .clear(clear),
    .o_r(or_u), .o_b(ob_u), .o_fwd_valid(fv_u),
    .o(o_u), .o_valid(ov_u), .o_ready(o_ready));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic longint val(input logic [7:0] v, input bit sg);
    return (sg && v[7]) ? longint'(v) - 256 : longint'(v);
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_ov = 0;
    m_fv = 0;
    m_r = '0;
    m_b = '0;
    for (int l = 0; l < 2; l++) begin
      m_ps[l] = 0; m_pu[l] = 0; m_os[l] = 0; m_ou[l] = 0;
    end
  endtask

  task automatic check_outs();
    logic [17:0] e;
    chk("o_valid", ov_s, m_ov);
    chk("o_valid_u", ov_u, m_ov);
    chk("fwd_valid", fv_s, m_fv);
    chk("fwd_valid_u", fv_u, m_fv);
    chk("o_r", or_s, m_r);
    chk("o_b", ob_s, m_b);
    chk("o_r_u", or_u, m_r);
    chk("o_b_u", ob_u, m_b);
    e = m_os[0][17:0]; chk("o_l0", o_s[17:0], e);
    e = m_os[1][17:0]; chk("o_l1", o_s[35:18], e);
    e = m_ou[0][17:0]; chk("o_u_l0", o_u[17:0], e);
    e = m_ou[1][17:0]; chk("o_u_l1", o_u[35:18], e);
  endtask

  task automatic step(input bit v, input logic [7:0] a,
                      input logic [15:0] b, input bit rdy,
                      input bit clr);
    bit rd, acc, drn, fin;
    logic [7:0] bl;
    in_valid = v; in1 = a; in2 = b; o_ready = rdy; clear = clr;
    #1;
    rd = !(m_n == NUM-1 && m_ov && !rdy);
    last_ir = ir_s;
    chk("in_ready", ir_s, rd);
    chk("in_ready_u", ir_u, rd);
    acc = v && rd && !clr;
    drn = m_ov && rdy;
    fin = 0;
    if (clr) begin
      m_n = 0;
      for (int l = 0; l < 2; l++) begin m_ps[l] = 0; m_pu[l] = 0; end
    end else if (acc) begin
      for (int l = 0; l < 2; l++) begin
        bl = b[l*8 +: 8];
        if (m_n == 0) begin m_ps[l] = 0; m_pu[l] = 0; end
        m_ps[l] += val(a, 1) * val(bl, 1);
        m_pu[l] += val(a, 0) * val(bl, 0);
      end
      if (m_n == NUM-1) begin
        fin = 1;
        m_n = 0;
        for (int l = 0; l < 2; l++) begin
          m_os[l] = m_ps[l]; m_ou[l] = m_pu[l];
        end
      end else m_n++;
    end
    m_ov = fin ? 1'b1 : (drn ? 1'b0 : m_ov);
    m_fv = acc;
    if (acc) begin m_r = a; m_b = b; end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic reset_now();
    reset = 1'b0;
    #1;
    chk("rst_o", o_s, 36'd0);
    chk("rst_ov", ov_s, 1'b0);
    chk("rst_fv", fv_s, 1'b0);
    chk("rst_or", or_s, 8'd0);
    chk("rst_ob", ob_s, 16'd0);
    chk("rst_ir", ir_s, 1'b1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_now();
    check_outs();

    step(1, 8'd2, {8'hFF, 8'd5}, 1, 0);
    step(1, 8'd3, {8'hFF, 8'd6}, 1, 0);
    step(1, 8'd4, {8'hFF, 8'd7}, 1, 0);
    chk("lit_basic_l0", o_s[17:0], 18'd56);
    chk("lit_basic_l1", o_s[35:18], 18'h3FFF7);
    chk("lit_basic_ov", ov_s, 1'b1);

    for (int i = 0; i < 3; i++) step(1, 8'h80, {8'h7F, 8'h80}, 1, 0);
    chk("lit_ext_l0", o_s[17:0], 18'd49152);
    chk("lit_ext_l1", o_s[35:18], 18'h34180);

    for (int i = 0; i < 3; i++) step(1, 8'hFF, 16'hFFFF, 1, 0);
    chk("lit_uns_l0", o_u[17:0], 18'd195075);
    chk("lit_uns_l1", o_u[35:18], 18'd195075);
    chk("lit_sgn_m1", o_s[17:0], 18'd3);

    step(1, 8'd1, 16'h0101, 0, 0);
    step(1, 8'd2, 16'h0202, 0, 0);
    step(1, 8'd3, 16'h0303, 0, 0);
    chk("lit_stall", last_ir, 1'b0);
    step(1, 8'd3, 16'h0303, 0, 0);
    chk("lit_hold", o_s[17:0], 18'd3);
    step(1, 8'd3, 16'h0303, 1, 0);
    chk("lit_bp_res", o_s[17:0], 18'd14);

    for (int i = 0; i < 6; i++)
      step(1, 8'($urandom), 16'($urandom), 1, 0);

    step(1, 8'd9, 16'h0909, 0, 0);
    step(1, 8'd9, 16'h0909, 0, 0);
    step(1, 8'd7, 16'h0707, 0, 1);
    chk("lit_clr_fwd", fv_s, 1'b0);
    step(1, 8'd1, 16'h0102, 1, 0);
    step(1, 8'd1, 16'h0102, 1, 0);
    step(1, 8'd1, 16'h0102, 1, 0);
    chk("lit_clr_sum", o_s[17:0], 18'd6);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_now();
      step($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pe_acc.md
# pe_acc

Parametrised systolic processing element for the fully-connected array. It forwards its left and top operands to the neighbouring PEs and accumulates `LANES` independent dot products of `NUM` terms each. Each completed result is delivered through a valid/ready output register with backpressure. It replaces the single-lane, free-running PE and adds lane parallelism, a signed/unsigned build option, abort via `clear`, and flow control.

## Interface
- `NUM`, 3: terms per dot product (≥1).
- `INLEFT_W`, 8: width of left operand `in1`.
- `INTOP_W`, 8: width of one top operand lane.
- `LANES`, 1: parallel top lanes / accumulators.
- `SIGNED`, 1: 1 = two's-complement operands, 0 = unsigned.
- `ACC_W`, derived = `INLEFT_W+INTOP_W+$clog2(NUM)` (min +1 when `NUM`=1): per-lane accumulator/result width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `in1` in `INLEFT_W`: left operand, shared by all lanes.
- `in2` in `LANES*INTOP_W`: top operands, lane 0 at LSBs.
- `in_valid` in 1: term present on `in1`/`in2`.
- `in_ready` out 1: term accepted when `in_valid && in_ready`.
- `clear` in 1: synchronous abort of the dot product in progress.
- `o_r` out `INLEFT_W`: registered copy of last accepted `in1`.
- `o_b` out `LANES*INTOP_W`: registered copy of last accepted `in2`.
- `o_fwd_valid` out 1: one-cycle pulse, `o_r`/`o_b` updated this cycle.
- `o` out `LANES*ACC_W`: results, lane 0 at LSBs.
- `o_valid` out 1: `o` holds an unconsumed result.
- `o_ready` in 1: downstream accepts `o` when `o_valid && o_ready`.

## Operation
- Term counter `cnt` runs 0..`NUM`-1. An accepted term with `cnt`==0 starts a new sum. `cnt` wraps to 0 after `NUM`-1.
- Per lane, on accept: `acc <= (cnt==0 ? 0 : acc) + in1*in2[lane]`.
  - Product is `INLEFT_W+INTOP_W` bits, sign- or zero-extended to `ACC_W` per `SIGNED`.
  - No overflow is possible, so there is no saturation and no wrap.
- On acceptance of term `cnt`==`NUM`-1: `o <= acc_next` for all lanes and `o_valid <= 1`.
- `o_valid` clears on `o_valid && o_ready`, unless a new last term is accepted in the same cycle. In that case `o` is overwritten and `o_valid` stays 1.
- `in_ready = !(cnt==NUM-1 && o_valid && !o_ready)`. Only the last term stalls; non-last terms are always accepted.
- Forwarding: on every accept, `o_r <= in1`, `o_b <= in2`, `o_fwd_valid <= 1`; otherwise `o_fwd_valid <= 0` and `o_r`/`o_b` hold.
- `clear`: `cnt <= 0`, accumulators zeroed.
  - Same-cycle `in_valid` is discarded: no accumulate, no forward.
  - `o`/`o_valid` are unaffected, and a pending result may still drain that cycle.
  - `in_ready` is not gated by `clear`.
- Output register FSM: EMPTY (`o_valid`=0) → FULL on last-term accept. FULL → EMPTY on drain with no new last term. FULL → FULL on drain plus new last term, or no drain.

## Timing
- Reset values: `o`, `o_r`, `o_b` = 0; `o_valid`, `o_fwd_valid` = 0; `cnt` = 0; accumulators = 0. `in_ready` = 1 after reset.
- Latency: result visible on `o` with `o_valid`=1 one clock after the edge that accepts the last term.
- Forward latency: 1 clock.
- Peak throughput: one term per clock, so one result per `NUM` clocks with `o_ready` held high.
- `in_ready` is combinational from `o_ready`, `o_valid` and `cnt`. There is no combinational path from `in_valid` to any output.
- Reset asserted mid-product: partial sum and pending result are lost. The first accepted term after release is term 0.

## Structure
- Package `pe_pkg`: `acc_w(INLEFT_W, INTOP_W, NUM)` function, `typedef enum {OUT_EMPTY, OUT_FULL}`, and lane slice helper.
- Sub-module `pe_lane_mac` (one multiply + accumulate register, `SIGNED` aware), generated `LANES` times. The top level holds the counter, handshake, forwarding and output registers.

## Test plan
All scenarios use `NUM`=3, 8-bit operands, `LANES`=2, `SIGNED`=1, `ACC_W`=18.
- Reset: drive `reset`=0 mid-traffic → all outputs 0, `in_ready`=1 after release, next term treated as term 0.
- Basic sum: `in1`=2,3,4; lane0 `in2`=5,6,7; lane1 = −1,−1,−1 → one clock after 3rd accept, lane0=56, lane1=−9, `o_valid`=1. `o_fwd_valid` pulses 3 times with matching `o_r`/`o_b`.
- Extremes: `in1`=−128 ×3 with lane0 `in2`=−128 ×3 and lane1 `in2`=127 ×3 → lane0=49152, lane1=−48768.
- Unsigned build (`SIGNED`=0): 255×255 ×3 → 195075 on both lanes.
- Backpressure: `o_ready`=0 after first result. Second product's first two terms are accepted, `in_ready`=0 on the third. `o` stays stable. Raising `o_ready` → third term accepted that cycle and the new result appears next clock.
- Streaming: `in_valid`=1 for 6 clocks with `o_ready`=1 → two results exactly 3 clocks apart. Drain and a new result in the same cycle keep `o_valid`=1.
- `clear` after 2 terms, asserted together with `in_valid` → no forward pulse; the following 3 terms produce a sum of only those terms; a pending `o` is unchanged.
